// File: rtl/lut_mult_accum_if.sv
// Handshake bundle between the constant multiplier and the block accumulator,
// plus the result port that feeds the next stage.
interface lut_mult_accum_if #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PROD_WIDTH-1:0] in_prod;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACC_WIDTH-1:0]  out_sum;
  logic [CNT_WIDTH-1:0]  out_cnt;
  logic                  out_sat;

  // Producer of products / consumer of results.
  modport master (
    output in_valid, in_prod, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_sat
  );

  // The accumulator itself.
  modport slave (
    input  in_valid, in_prod, flush, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_sat
  );
endinterface

// File: rtl/lut_mult_accum.sv
// Block accumulator: sums BLOCK_LEN unsigned products (or fewer on flush),
// saturating at all-ones, and holds each block result until it is taken.
//
// state   | meaning
// --------+------------------------------------------------
// S_IDLE  | no beats in the current block
// S_ACCUM | 1..BLOCK_LEN-1 beats taken
// S_DONE  | block result held on out_*, input stalled
module lut_mult_accum #(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int BLOCK_LEN  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic              clk,
  input  logic              rst,
  lut_mult_accum_if.slave   bus_if
);

  localparam int SUM_WIDTH = ACC_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  sat_q, sat_d;
  logic [ACC_WIDTH-1:0]  out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic                  out_sat_q, out_sat_d;
  logic                  out_valid_q, out_valid_d;

  logic                  in_ready;
  logic                  beat;
  logic                  block_full;
  logic [SUM_WIDTH-1:0]  sum_ext;

  assign beat       = bus_if.in_valid && in_ready;
  // One extra bit catches overflow of the unsigned running sum.
  assign sum_ext    = {1'b0, acc_q} + SUM_WIDTH'(bus_if.in_prod);
  assign block_full = (cnt_d == CNT_WIDTH'(BLOCK_LEN));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a beat taken with flush is counted before the block closes.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (beat) begin
          state_d = (bus_if.flush || block_full) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (bus_if.flush || (beat && block_full)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_valid_q && bus_if.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: ready depends on state only, so no path from valid or out_ready.
  always_comb begin
    in_ready = (state_q != S_DONE);
  end

  assign bus_if.in_ready  = in_ready;
  assign bus_if.out_valid = out_valid_q;
  assign bus_if.out_sum   = out_sum_q;
  assign bus_if.out_cnt   = out_cnt_q;
  assign bus_if.out_sat   = out_sat_q;

  // Accumulator update: the first beat of a block reloads, later beats add and saturate.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (beat) begin
      if (state_q == S_IDLE) begin
        acc_d = ACC_WIDTH'(bus_if.in_prod);
        cnt_d = CNT_WIDTH'(1);
        sat_d = 1'b0;
      end else begin
        if (sum_ext[ACC_WIDTH]) begin
          acc_d = '1;
          sat_d = 1'b1;
        end else begin
          acc_d = sum_ext[ACC_WIDTH-1:0];
        end
        cnt_d = cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Result capture on the edge that enters S_DONE; held otherwise.
  always_comb begin
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_sat_d   = out_sat_q;
    out_valid_d = (state_d == S_DONE);
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      out_sum_d = acc_d;
      out_cnt_d = cnt_d;
      out_sat_d = sat_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_sat_q   <= out_sat_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_lut_mult_accum.sv
// Bench for lut_mult_accum: a 16-bit-accumulator instance (a) and a
// single-beat-block instance (b); expected results queued, monitors compare.
module tb_lut_mult_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lut_mult_accum_if #(.PROD_WIDTH(16), .ACC_WIDTH(16), .CNT_WIDTH(5)) a_if ();
  lut_mult_accum_if #(.PROD_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(5)) b_if ();

  lut_mult_accum #(.PROD_WIDTH(16), .ACC_WIDTH(16), .BLOCK_LEN(16), .CNT_WIDTH(5))
    dut_a (.clk(clk), .rst(rst), .bus_if(a_if));
  lut_mult_accum #(.PROD_WIDTH(16), .ACC_WIDTH(24), .BLOCK_LEN(1), .CNT_WIDTH(5))
    dut_b (.clk(clk), .rst(rst), .bus_if(b_if));

  typedef struct {
    logic [31:0] sum;
    logic [31:0] cnt;
    logic        sat;
  } res_t;

  res_t q_a[$];
  res_t q_b[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out_a = 0;
  int   n_out_b = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic res_t mk(input int s, input int c, input bit st);
    res_t r;
    r.sum = s;
    r.cnt = c;
    r.sat = st;
    return r;
  endfunction

  // Called at a falling edge; returns at the falling edge after the beat is taken.
  task automatic a_send(input logic [15:0] p, input logic fl);
    int n = 0;
    a_if.in_valid = 1'b1;
    a_if.in_prod  = p;
    a_if.flush    = fl;
    while (!a_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL a_send_timeout: in_ready stuck 0 for %0d cycles, required 1", n);
    end
    @(negedge clk);
    a_if.in_valid = 1'b0;
    a_if.flush    = 1'b0;
  endtask

  // Monitor a: compare on the first cycle of each result, then check it stays held.
  initial begin
    res_t cur;
    bit   seen = 1'b0;
    cur = mk(0, 0, 1'b0);
    forever begin
      @(negedge clk);
      if (a_if.out_valid === 1'b1) begin
        if (!seen) begin
          n_out_a++;
          if (q_a.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_out: got sum %0d, required no output", a_if.out_sum);
          end else begin
            cur = q_a.pop_front();
            chk("a_sum", 32'(a_if.out_sum), cur.sum);
            chk("a_cnt", 32'(a_if.out_cnt), cur.cnt);
            chk("a_sat", 32'(a_if.out_sat), 32'(cur.sat));
          end
          seen = 1'b1;
        end else begin
          chk("a_hold_sum", 32'(a_if.out_sum), cur.sum);
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  // Monitor b.
  initial begin
    res_t cur;
    bit   seen = 1'b0;
    forever begin
      @(negedge clk);
      if (b_if.out_valid === 1'b1) begin
        if (!seen) begin
          n_out_b++;
          if (q_b.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_out: got sum %0d, required no output", b_if.out_sum);
          end else begin
            cur = q_b.pop_front();
            chk("b_sum", 32'(b_if.out_sum), cur.sum);
            chk("b_cnt", 32'(b_if.out_cnt), cur.cnt);
            chk("b_sat", 32'(b_if.out_sat), 32'(cur.sat));
          end
          seen = 1'b1;
        end
      end else begin
        seen = 1'b0;
      end
    end
  end

  initial begin
    int n_before;
    a_if.in_valid = 1'b0; a_if.in_prod = '0; a_if.flush = 1'b0; a_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.in_prod = '0; b_if.flush = 1'b0; b_if.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 32'(a_if.out_valid), 0);
    chk("rst_out_sum", 32'(a_if.out_sum), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(a_if.in_ready), 1);
    chk("rst_out_cnt", 32'(a_if.out_cnt), 0);

    // Basic: X=0..15 times 2, back to back.
    q_a.push_back(mk(240, 16, 1'b0));
    for (int i = 0; i < 16; i++) a_send(16'(2 * i), 1'b0);
    chk("basic_valid_rise", 32'(a_if.out_valid), 1);
    @(negedge clk);
    chk("basic_valid_one_cycle", 32'(a_if.out_valid), 0);

    // Backpressure: result held 5 cycles, next beat waits until after handshake.
    q_a.push_back(mk(240, 16, 1'b0));
    for (int i = 0; i < 15; i++) a_send(16'(2 * i), 1'b0);
    a_if.out_ready = 1'b0;
    a_send(16'd30, 1'b0);
    a_if.in_valid = 1'b1;
    a_if.in_prod  = 16'd32;
    for (int k = 0; k < 5; k++) begin
      chk("bp_in_ready_low", 32'(a_if.in_ready), 0);
      chk("bp_valid_held", 32'(a_if.out_valid), 1);
      chk("bp_sum_held", 32'(a_if.out_sum), 240);
      @(negedge clk);
    end
    a_if.out_ready = 1'b1;
    chk("bp_no_bypass", 32'(a_if.in_ready), 0);
    @(negedge clk);
    chk("bp_valid_drop", 32'(a_if.out_valid), 0);
    chk("bp_ready_back", 32'(a_if.in_ready), 1);
    @(negedge clk);
    a_if.in_valid = 1'b0;
    q_a.push_back(mk(32, 1, 1'b0));
    a_if.flush = 1'b1;
    @(negedge clk);
    a_if.flush = 1'b0;
    @(negedge clk);

    // Saturation with a 16-bit accumulator, then a clean block.
    q_a.push_back(mk(65535, 16, 1'b1));
    for (int i = 0; i < 16; i++) a_send(16'd65025, 1'b0);
    q_a.push_back(mk(32, 16, 1'b0));
    for (int i = 0; i < 16; i++) a_send(16'd2, 1'b0);

    // Flush together with the third beat.
    q_a.push_back(mk(18, 3, 1'b0));
    a_send(16'd4, 1'b0);
    a_send(16'd6, 1'b0);
    a_send(16'd8, 1'b1);
    @(negedge clk);
    @(negedge clk);
    n_before = n_out_a;
    a_if.flush = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("idle_flush_no_valid", 32'(a_if.out_valid), 0);
    end
    a_if.flush = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("idle_flush_no_result", n_out_a, n_before);

    // Asynchronous reset after 7 beats of a block.
    for (int i = 0; i < 7; i++) a_send(16'd5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sum", 32'(a_if.out_sum), 0);
    chk("mid_rst_cnt", 32'(a_if.out_cnt), 0);
    chk("mid_rst_valid", 32'(a_if.out_valid), 0);
    chk("mid_rst_in_ready", 32'(a_if.in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    q_a.push_back(mk(16, 16, 1'b0));
    for (int i = 0; i < 16; i++) a_send(16'd1, 1'b0);
    @(negedge clk);

    // Single-beat blocks with one ready bubble after each beat.
    q_b.push_back(mk(10, 1, 1'b0));
    q_b.push_back(mk(20, 1, 1'b0));
    b_if.in_valid = 1'b1;
    b_if.in_prod  = 16'd10;
    chk("b1_ready_first", 32'(b_if.in_ready), 1);
    @(negedge clk);
    chk("b1_bubble", 32'(b_if.in_ready), 0);
    b_if.in_prod = 16'd20;
    @(negedge clk);
    chk("b1_ready_second", 32'(b_if.in_ready), 1);
    chk("b1_valid_gap", 32'(b_if.out_valid), 0);
    @(negedge clk);
    b_if.in_valid = 1'b0;
    chk("b1_bubble2", 32'(b_if.in_ready), 0);
    @(negedge clk);
    chk("b1_ready_after", 32'(b_if.in_ready), 1);
    repeat (3) @(negedge clk);

    chk("a_queue_empty", q_a.size(), 0);
    chk("b_queue_empty", q_b.size(), 0);
    chk("a_result_count", n_out_a, 7);
    chk("b_result_count", n_out_b, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL global_timeout: reached %0t, required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
